// File: rtl/motion_pkg.sv
// motion_pkg: shared definitions for the motion bounding-box custom instruction.
//   OP_*    : opcode encodings carried on the CI op field.
//   COUNT_W : width of the live and snapshot changed-pixel counters.
//   bbox_t  : snapshot bounding box, 16-bit fields as returned to software.
package motion_pkg;

  localparam logic [1:0] OP_ACCUM  = 2'd0;
  localparam logic [1:0] OP_READ_X = 2'd1;
  localparam logic [1:0] OP_READ_Y = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  localparam int unsigned COUNT_W = 20;

  typedef struct packed {
    logic [15:0] minX;
    logic [15:0] maxX;
    logic [15:0] minY;
    logic [15:0] maxY;
  } bbox_t;

endpackage

// File: rtl/motion_bbox_ci_if.sv
// motion_bbox_ci_if: custom-instruction call/return bundle.
//   start, iseId, op, valueA, valueB : call request (master -> slave)
//   done, result                     : one-cycle completion and return value (slave -> master)
interface motion_bbox_ci_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic              start;
  logic [7:0]        iseId;
  logic [1:0]        op;
  logic [WORD_W-1:0] valueA;
  logic [WORD_W-1:0] valueB;
  logic              done;
  logic [31:0]       result;

  modport master (
    output start, iseId, op, valueA, valueB,
    input  done, result
  );

  modport slave (
    input  start, iseId, op, valueA, valueB,
    output done, result
  );

endinterface

// File: rtl/motion_word_scan.sv
// motion_word_scan: combinational scan of one XOR difference word.
//   diff_i    in  WORD_W   changed-pixel mask (bit i = pixel x+i)
//   lo_o      out IDX_W    index of lowest set bit (0 when diff_i == 0)
//   hi_o      out IDX_W    index of highest set bit (0 when diff_i == 0)
//   nonzero_o out 1        any bit set
//   pc_o      out PC_W     number of set bits
module motion_word_scan #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IDX_W  = $clog2(WORD_W),
  parameter int unsigned PC_W   = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] diff_i,
  output logic [IDX_W-1:0]  lo_o,
  output logic [IDX_W-1:0]  hi_o,
  output logic              nonzero_o,
  output logic [PC_W-1:0]   pc_o
);

  always_comb begin
    lo_o      = '0;
    hi_o      = '0;
    pc_o      = '0;
    nonzero_o = |diff_i;
    // Ascending pass: last hit is the highest bit; descending pass: last hit is the lowest.
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (diff_i[i]) begin
        hi_o = IDX_W'(i);
        pc_o = pc_o + PC_W'(1);
      end
      if (diff_i[WORD_W-1-i]) begin
        lo_o = IDX_W'(WORD_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/motion_bbox_ci.sv
// motion_bbox_ci: motion bounding-box custom instruction.
// XORs previous/current edge-map words, tracks pixel position, accumulates the
// per-frame bounding box and changed-pixel count, and snapshots them at end of frame.
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of motion_bbox_ci_if (start/iseId/op/valueA/valueB -> done/result)
// Build option: MOTION_BBOX_THRESH_EN -- a word qualifies only if its popcount >= THRESH.
module motion_bbox_ci
  import motion_pkg::*;
#(
  parameter logic [7:0]  CUSTOM_ID = 8'd1,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned FRAME_W   = 640,
  parameter int unsigned FRAME_H   = 480,
  parameter int unsigned THRESH    = 4
) (
  input logic            clk,
  input logic            rst,
  motion_bbox_ci_if.slave bus
);

  localparam int unsigned X_W   = $clog2(FRAME_W);
  localparam int unsigned Y_W   = $clog2(FRAME_H);
  localparam int unsigned IDX_W = $clog2(WORD_W);
  localparam int unsigned PC_W  = $clog2(WORD_W + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W - WORD_W);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);

  // Minimum popcount for a word to qualify; 1 is equivalent to "diff nonzero".
`ifdef MOTION_BBOX_THRESH_EN
  localparam int unsigned QUAL_MIN = THRESH;
`else
  localparam int unsigned QUAL_MIN = 1;
`endif

  logic [X_W-1:0]     x_q, x_d, min_x_q, min_x_d, max_x_q, max_x_d;
  logic [Y_W-1:0]     y_q, y_d, min_y_q, min_y_d, max_y_q, max_y_d;
  logic               any_q, any_d;
  logic [COUNT_W-1:0] count_q, count_d;
  bbox_t              snap_q, snap_d;
  logic               s_valid_q, s_valid_d;
  logic [COUNT_W-1:0] s_count_q, s_count_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;

  logic [WORD_W-1:0] diff;
  logic [IDX_W-1:0]  lo, hi;
  logic              nonzero;
  logic [PC_W-1:0]   pc;

  assign diff = bus.valueA ^ bus.valueB;

  motion_word_scan #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .PC_W   (PC_W)
  ) u_scan (
    .diff_i    (diff),
    .lo_o      (lo),
    .hi_o      (hi),
    .nonzero_o (nonzero),
    .pc_o      (pc)
  );

  logic               accept, qualify, last_col, eof, clear_live;
  logic [X_W-1:0]     cand_lo, cand_hi;
  logic [COUNT_W:0]   count_sum;

  always_comb begin
    accept     = bus.start && (bus.iseId == CUSTOM_ID);
    // nonzero gate keeps lo/hi meaningful even if THRESH is configured as 0.
    qualify    = nonzero && (32'(pc) >= QUAL_MIN);
    cand_lo    = x_q + X_W'(lo);
    cand_hi    = x_q + X_W'(hi);
    last_col   = (x_q == X_LAST);
    eof        = last_col && (y_q == Y_LAST);
    count_sum  = {1'b0, count_q} + (COUNT_W + 1)'(pc);
    clear_live = 1'b0;

    x_d       = x_q;
    y_d       = y_q;
    min_x_d   = min_x_q;
    max_x_d   = max_x_q;
    min_y_d   = min_y_q;
    max_y_d   = max_y_q;
    any_d     = any_q;
    count_d   = count_q;
    snap_d    = snap_q;
    s_valid_d = s_valid_q;
    s_count_d = s_count_q;
    done_d    = accept;
    result_d  = '0;

    if (accept) begin
      unique case (bus.op)
        OP_ACCUM: begin
          if (qualify) begin
            if (cand_lo < min_x_q) min_x_d = cand_lo;
            if (cand_hi > max_x_q) max_x_d = cand_hi;
            if (y_q < min_y_q)     min_y_d = y_q;
            if (y_q > max_y_q)     max_y_d = y_q;
            any_d   = 1'b1;
            count_d = count_sum[COUNT_W] ? '1 : count_sum[COUNT_W-1:0];
          end
          if (last_col) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(WORD_W);
          end
          // Snapshot takes the post-update live values so the last word counts.
          if (eof) begin
            snap_d.minX = 16'(min_x_d);
            snap_d.maxX = 16'(max_x_d);
            snap_d.minY = 16'(min_y_d);
            snap_d.maxY = 16'(max_y_d);
            s_valid_d   = any_d;
            s_count_d   = count_d;
            clear_live  = 1'b1;
          end
          result_d = {31'b0, eof};
        end
        OP_READ_X: result_d = s_valid_q ? {snap_q.maxX, snap_q.minX} : '0;
        OP_READ_Y: result_d = s_valid_q ? {snap_q.maxY, snap_q.minY} : '0;
        OP_STATUS: begin
          result_d   = {s_valid_q, 11'b0, s_count_q};
          clear_live = bus.valueA[0];
        end
        default: result_d = '0;
      endcase
    end

    if (clear_live) begin
      x_d     = '0;
      y_d     = '0;
      min_x_d = '1;
      max_x_d = '0;
      min_y_d = '1;
      max_y_d = '0;
      any_d   = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      min_x_q   <= '1;
      max_x_q   <= '0;
      min_y_q   <= '1;
      max_y_q   <= '0;
      any_q     <= 1'b0;
      count_q   <= '0;
      snap_q    <= '0;
      s_valid_q <= 1'b0;
      s_count_q <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      min_x_q   <= min_x_d;
      max_x_q   <= max_x_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      any_q     <= any_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
      s_valid_q <= s_valid_d;
      s_count_q <= s_count_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_motion_bbox_ci.sv
// tb_motion_bbox_ci: randomized self-checking bench for motion_bbox_ci with a
// word-index/pixel-coordinate reference model (64x4 frame, 8 words per frame).
module tb_motion_bbox_ci;
  import motion_pkg::*;

  localparam int unsigned FW  = 64;
  localparam int unsigned FH  = 4;
  localparam int unsigned WW  = 32;
  localparam int unsigned TH  = 4;
  localparam int unsigned WPR = FW / WW;
  localparam int unsigned WPF = WPR * FH;
  localparam logic [7:0]  ID  = 8'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motion_bbox_ci_if #(.WORD_W(WW)) bus_if ();

  motion_bbox_ci #(
    .CUSTOM_ID (ID),
    .WORD_W    (WW),
    .FRAME_W   (FW),
    .FRAME_H   (FH),
    .THRESH    (TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: frame position as word index, box in pixel coordinates.
  int pos, mnx, mxx, mny, mxy, cnt;
  bit any;
  int smnx, smxx, smny, smxy, scnt;
  bit sv;

  function automatic void m_clear_live();
    pos = 0; mnx = 1 << 30; mxx = -1; mny = 1 << 30; mxy = -1; cnt = 0; any = 0;
  endfunction

  function automatic void m_reset();
    m_clear_live();
    sv = 0; smnx = 0; smxx = 0; smny = 0; smxy = 0; scnt = 0;
  endfunction

  function automatic bit m_accum(input logic [31:0] d);
    int pcnt, lo, hi, px, py;
    bit q, eofb;
    pcnt = $countones(d);
`ifdef MOTION_BBOX_THRESH_EN
    q = (d != 0) && (pcnt >= TH);
`else
    q = (d != 0);
`endif
    px = int'(pos % WPR) * WW;
    py = pos / WPR;
    if (q) begin
      lo = -1; hi = -1;
      for (int i = 0; i < 32; i++) if (d[i]) begin if (lo < 0) lo = i; hi = i; end
      if (px + lo < mnx) mnx = px + lo;
      if (px + hi > mxx) mxx = px + hi;
      if (py < mny) mny = py;
      if (py > mxy) mxy = py;
      any = 1;
      cnt = (cnt + pcnt > 20'hFFFFF) ? 20'hFFFFF : cnt + pcnt;
    end
    eofb = (pos == WPF - 1);
    if (eofb) begin
      sv = any; smnx = mnx; smxx = mxx; smny = mny; smxy = mxy; scnt = cnt;
      m_clear_live();
    end else begin
      pos++;
    end
    return eofb;
  endfunction

  function automatic logic [31:0] m_read_x();
    return sv ? {16'(smxx), 16'(smnx)} : 32'h0;
  endfunction

  function automatic logic [31:0] m_read_y();
    return sv ? {16'(smxy), 16'(smny)} : 32'h0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [19:0] c;
    c = 20'(scnt);
    return {sv, 11'b0, c};
  endfunction

  function automatic logic [31:0] rand_diff();
    logic [31:0] m;
    int len, sh;
    case ($urandom_range(0, 3))
      0: m = 32'h0;
      1: begin
        len = int'($urandom_range(1, 8)); sh = int'($urandom_range(0, 24));
        m = ((32'h1 << len) - 32'h1) << sh;
      end
      2: m = $urandom;
      default: m = $urandom & $urandom & $urandom;
    endcase
    return m;
  endfunction

  task automatic do_call(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] id, output logic dn, output logic [31:0] res);
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.iseId  = id;
    bus_if.op     = op;
    bus_if.valueA = a;
    bus_if.valueB = b;
    @(posedge clk);
    #1;
    dn  = bus_if.done;
    res = bus_if.result;
    bus_if.start = 1'b0;
  endtask

  // One ACCUM call with model update; returns observed and expected values.
  task automatic accum(input logic [31:0] d, output logic dn, output logic [31:0] res,
                       output logic [31:0] exp);
    logic [31:0] a;
    a = $urandom;
    do_call(OP_ACCUM, a, a ^ d, ID, dn, res);
    exp = {31'b0, m_accum(d)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic dn; logic [31:0] res;
    do_reset();
    #1;
    vectors++;
    if (bus_if.done !== 1'b0 || bus_if.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs done=%b result=%h want done=0 result=0", bus_if.done, bus_if.result);
    end
    do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status done=%b result=%h want done=1 result=00000000", dn, res);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus_if.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_cycle done=%b want 0", bus_if.done);
    end
  endtask

  task automatic test_single_word();
    logic dn; logic [31:0] res, exp;
    do_reset();
    for (int w = 0; w < int'(WPF); w++) begin
      accum((w == 3) ? 32'h0000_0F00 : 32'h0, dn, res, exp);
      vectors++;
      if (dn !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL single_accum w=%0d done=%b result=%h want %h", w, dn, res, exp);
      end
    end
    do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h002B_0028) begin
      miscompares++;
      $display("FAIL single_read_x result=%h want 002b0028", res);
    end
    do_call(OP_READ_Y, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h0001_0001) begin
      miscompares++;
      $display("FAIL single_read_y result=%h want 00010001", res);
    end
    do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL single_status result=%h want 80000004", res);
    end
  endtask

  task automatic test_quiet_frame();
    logic dn; logic [31:0] res, exp;
    for (int w = 0; w < int'(WPF); w++) accum(32'h0, dn, res, exp);
    vectors++;
    if (res !== 32'h1) begin
      miscompares++;
      $display("FAIL quiet_eof result=%h want 00000001", res);
    end
    do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL quiet_status result=%h want 00000000", res);
    end
    do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL quiet_read_x result=%h want 00000000", res);
    end
  endtask

  task automatic test_resync();
    logic dn; logic [31:0] res, exp;
    for (int w = 0; w < 7; w++) accum($urandom | 32'h1, dn, res, exp);
    exp = m_status();
    m_clear_live();
    do_call(OP_STATUS, 32'h1, 32'h0, ID, dn, res);
    vectors++;
    if (dn !== 1'b1 || res !== exp) begin
      miscompares++;
      $display("FAIL resync_status result=%h want %h", res, exp);
    end
    for (int w = 0; w < int'(WPF); w++) begin
      accum((w == 0) ? 32'h1 : 32'h0, dn, res, exp);
      vectors++;
      if (dn !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL resync_accum w=%0d result=%h want %h", w, res, exp);
      end
    end
    do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (res !== 32'h0 || res !== m_read_x()) begin
      miscompares++;
      $display("FAIL resync_read_x result=%h want 00000000", res);
    end
    do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (res !== m_status()) begin
      miscompares++;
      $display("FAIL resync_final_status result=%h want %h", res, m_status());
    end
  endtask

  task automatic test_threshold();
    logic dn; logic [31:0] res, exp;
    logic [31:0] pats [2];
    int hit;
    pats[0] = 32'h7;
    pats[1] = 32'hF;
    for (int p = 0; p < 2; p++) begin
      hit = int'($urandom_range(0, WPF - 1));
      for (int w = 0; w < int'(WPF); w++) accum((w == hit) ? pats[p] : 32'h0, dn, res, exp);
      do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
      vectors++;
      if (res !== m_status()) begin
        miscompares++;
        $display("FAIL thresh_status pat=%h result=%h want %h", pats[p], res, m_status());
      end
      do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
      vectors++;
      if (res !== m_read_x()) begin
        miscompares++;
        $display("FAIL thresh_read_x pat=%h result=%h want %h", pats[p], res, m_read_x());
      end
    end
  endtask

  task automatic test_foreign_id();
    logic dn; logic [31:0] res, exp;
    logic [7:0] bad;
    for (int w = 0; w < int'(WPF); w++) begin
      if (w == 2 || w == 5) begin
        bad = (w == 2) ? 8'h02 : 8'h00;
        do_call(OP_ACCUM, 32'h0, $urandom | 32'h1, bad, dn, res);
        vectors++;
        if (dn !== 1'b0 || res !== 32'h0) begin
          miscompares++;
          $display("FAIL foreign_call id=%h done=%b result=%h want done=0 result=0", bad, dn, res);
        end
      end
      accum(rand_diff(), dn, res, exp);
      vectors++;
      if (dn !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL foreign_accum w=%0d result=%h want %h", w, res, exp);
      end
    end
    do_call(OP_READ_Y, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (res !== m_read_y()) begin
      miscompares++;
      $display("FAIL foreign_read_y result=%h want %h", res, m_read_y());
    end
  endtask

  task automatic test_mid_reset();
    logic dn; logic [31:0] res, exp;
    for (int w = 0; w < 3; w++) accum($urandom, dn, res, exp);
    @(negedge clk);
    rst = 1'b1;
    bus_if.start = 1'b1; bus_if.iseId = ID; bus_if.op = OP_ACCUM;
    bus_if.valueA = 32'h0; bus_if.valueB = 32'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.start = 1'b0;
    m_reset();
    @(posedge clk); #1;
    vectors++;
    if (bus_if.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cycle_done done=%b want 0", bus_if.done);
    end
    do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (res !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_snapshot result=%h want 00000000", res);
    end
    for (int w = 0; w < int'(WPF); w++) begin
      accum(rand_diff(), dn, res, exp);
      vectors++;
      if (dn !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL midreset_accum w=%0d result=%h want %h", w, res, exp);
      end
    end
    do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
    vectors++;
    if (res !== m_read_x()) begin
      miscompares++;
      $display("FAIL midreset_read_x result=%h want %h", res, m_read_x());
    end
  endtask

  task automatic test_random_frames();
    logic dn; logic [31:0] res, exp;
    for (int f = 0; f < 20; f++) begin
      for (int w = 0; w < int'(WPF); w++) begin
        if ($urandom_range(0, 5) == 0) begin
          @(negedge clk);
          @(posedge clk); #1;
          vectors++;
          if (bus_if.done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done done=%b want 0", bus_if.done);
          end
        end
        accum(rand_diff(), dn, res, exp);
        vectors++;
        if (dn !== 1'b1 || res !== exp) begin
          miscompares++;
          $display("FAIL rand_accum f=%0d w=%0d result=%h want %h", f, w, res, exp);
        end
      end
      // Reads issued back-to-back right after the end-of-frame call.
      do_call(OP_READ_X, 32'h0, 32'h0, ID, dn, res);
      vectors++;
      if (dn !== 1'b1 || res !== m_read_x()) begin
        miscompares++;
        $display("FAIL rand_read_x f=%0d result=%h want %h", f, res, m_read_x());
      end
      do_call(OP_READ_Y, 32'h0, 32'h0, ID, dn, res);
      vectors++;
      if (dn !== 1'b1 || res !== m_read_y()) begin
        miscompares++;
        $display("FAIL rand_read_y f=%0d result=%h want %h", f, res, m_read_y());
      end
      do_call(OP_STATUS, 32'h0, 32'h0, ID, dn, res);
      vectors++;
      if (dn !== 1'b1 || res !== m_status()) begin
        miscompares++;
        $display("FAIL rand_status f=%0d result=%h want %h", f, res, m_status());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.iseId  = 8'h0;
    bus_if.op     = OP_ACCUM;
    bus_if.valueA = 32'h0;
    bus_if.valueB = 32'h0;
    m_reset();
    test_reset();
    test_single_word();
    test_quiet_frame();
    test_resync();
    test_threshold();
    test_foreign_id();
    test_mid_reset();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
